// File: rtl/secuenciador_mux_dd_pkg.sv
// Shared constants for the E_Bloques_Datos step sequencer: step codes, modo
// encodings, FSM states and the first/last step range of each sequence.
package pkg_mux_dd;

  localparam logic [3:0] PASO_IDLE       = 4'h0;
  localparam logic [3:0] PASO_I          = 4'h1;
  localparam logic [3:0] PASO_MS         = 4'h2;
  localparam logic [3:0] PASO_FECHA_DIA  = 4'h3;
  localparam logic [3:0] PASO_FECHA_MES  = 4'h4;
  localparam logic [3:0] PASO_FECHA_ANIO = 4'h5;
  localparam logic [3:0] PASO_HORA_HORA  = 4'h6;
  localparam logic [3:0] PASO_HORA_MIN   = 4'h7;
  localparam logic [3:0] PASO_HORA_SEG   = 4'h8;
  localparam logic [3:0] PASO_CRONO_HORA = 4'h9;
  localparam logic [3:0] PASO_CRONO_MIN  = 4'hA;
  localparam logic [3:0] PASO_CRONO_SEG  = 4'hB;

  typedef enum logic [1:0] {
    MODO_INIT     = 2'b00,
    MODO_LECTURA  = 2'b01,
    MODO_CRONO    = 2'b10,
    MODO_INVALIDO = 2'b11
  } modo_t;

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    PEDIR   = 2'd1,
    ESPERAR = 2'd2,
    FIN     = 2'd3
  } estado_t;

  typedef struct packed {
    logic [3:0] primero;
    logic [3:0] ultimo;
  } rango_t;

  function automatic rango_t rango_de_modo(input logic [1:0] modo);
    rango_t r;
    case (modo)
      MODO_INIT:    r = '{primero: PASO_I,          ultimo: PASO_MS};
      MODO_LECTURA: r = '{primero: PASO_FECHA_DIA,  ultimo: PASO_CRONO_SEG};
      MODO_CRONO:   r = '{primero: PASO_CRONO_HORA, ultimo: PASO_CRONO_SEG};
      default:      r = '{primero: PASO_IDLE,       ultimo: PASO_IDLE};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/secuenciador_mux_dd_contador_espera.sv
// Per-step wait counter: cleared on request, counts while waiting, and flags the
// increment that brings the count to its all-ones maximum.
module contador_espera #(
  parameter int W_ESPERA = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic limpiar,
  input  logic habilitar,
  output logic terminal
);

  localparam logic [W_ESPERA-1:0] UNO       = {{(W_ESPERA-1){1'b0}}, 1'b1};
  localparam logic [W_ESPERA-1:0] PENULTIMO = {{(W_ESPERA-1){1'b1}}, 1'b0};

  logic [W_ESPERA-1:0] cuenta;

  always_ff @(posedge clk) begin
    if (reset || limpiar) begin
      cuenta <= '0;
    end else if (habilitar) begin
      cuenta <= cuenta + UNO;
    end
  end

  // High on the edge where the count would reach 2^W_ESPERA-1, so the timeout
  // lands exactly 2^W_ESPERA-1 waiting cycles after the request.
  assign terminal = habilitar && (cuenta == PENULTIMO);

endmodule

// File: rtl/secuenciador_mux_dd.sv
// Steps Selec_Mux_DD through the init / read / chronometer-write register lists,
// one bus transaction per step, with a per-step completion timeout.
module secuenciador_mux_dd
  import pkg_mux_dd::*;
#(
  parameter int W_ESPERA = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [1:0] modo,
  input  logic       fin_transaccion,
  output logic [3:0] Selec_Mux_DD,
  output logic       inicio_transaccion,
  output logic       ocupado,
  output logic       secuencia_lista,
  output logic       error_timeout
);

  estado_t    estado;
  logic [3:0] ultimo;
  rango_t     rango_inicio;
  logic       fin_espera;

  assign rango_inicio = rango_de_modo(modo);

  contador_espera #(.W_ESPERA(W_ESPERA)) u_contador_espera (
    .clk       (clk),
    .reset     (reset),
    .limpiar   (estado == PEDIR),
    .habilitar (estado == ESPERAR),
    .terminal  (fin_espera)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      estado             <= REPOSO;
      ultimo             <= PASO_IDLE;
      Selec_Mux_DD       <= PASO_IDLE;
      inicio_transaccion <= 1'b0;
      ocupado            <= 1'b0;
      secuencia_lista    <= 1'b0;
      error_timeout      <= 1'b0;
    end else begin
      inicio_transaccion <= 1'b0;
      secuencia_lista    <= 1'b0;
      case (estado)
        REPOSO: begin
          if (iniciar && (modo != MODO_INVALIDO)) begin
            ultimo             <= rango_inicio.ultimo;
            Selec_Mux_DD       <= rango_inicio.primero;
            inicio_transaccion <= 1'b1;
            ocupado            <= 1'b1;
            error_timeout      <= 1'b0;
            estado             <= PEDIR;
          end
        end
        PEDIR: begin
          estado <= ESPERAR;
        end
        ESPERAR: begin
          // A completion arriving on the timeout edge still counts as success.
          if (fin_transaccion) begin
            if (Selec_Mux_DD != ultimo) begin
              Selec_Mux_DD       <= Selec_Mux_DD + 4'd1;
              inicio_transaccion <= 1'b1;
              estado             <= PEDIR;
            end else begin
              secuencia_lista <= 1'b1;
              estado          <= FIN;
            end
          end else if (fin_espera) begin
            error_timeout <= 1'b1;
            Selec_Mux_DD  <= PASO_IDLE;
            ocupado       <= 1'b0;
            estado        <= REPOSO;
          end
        end
        FIN: begin
          Selec_Mux_DD <= PASO_IDLE;
          ocupado      <= 1'b0;
          estado       <= REPOSO;
        end
        default: begin
          Selec_Mux_DD <= PASO_IDLE;
          ocupado      <= 1'b0;
          estado       <= REPOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_mux_dd.sv
// Self-checking bench for secuenciador_mux_dd: a randomized bus responder drives
// each sequence and observed step codes are compared with the expected step list.
module tb_secuenciador_mux_dd;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic [1:0] modo = 2'b00;
  logic       fin_transaccion = 1'b0;
  logic [3:0] Selec_Mux_DD;
  logic       inicio_transaccion;
  logic       ocupado;
  logic       secuencia_lista;
  logic       error_timeout;

  int n_checks = 0;
  int n_fail = 0;

  logic [3:0] obs_q[$];
  int         n_lista;
  logic [3:0] lista_code;
  logic [3:0] code_done;
  logic       err_at_start;
  int         c_ult_inicio;
  int         c_lista;
  int         c_done;
  bit         done;

  always #5 clk = ~clk;

  secuenciador_mux_dd #(.W_ESPERA(8)) dut (
    .clk                (clk),
    .reset              (reset),
    .iniciar            (iniciar),
    .modo               (modo),
    .fin_transaccion    (fin_transaccion),
    .Selec_Mux_DD       (Selec_Mux_DD),
    .inicio_transaccion (inicio_transaccion),
    .ocupado            (ocupado),
    .secuencia_lista    (secuencia_lista),
    .error_timeout      (error_timeout)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: the register list each modo walks through.
  function automatic int exp_first(input logic [1:0] m);
    return (m == 2'b00) ? 1 : (m == 2'b01) ? 3 : 9;
  endfunction

  function automatic int exp_last(input logic [1:0] m);
    return (m == 2'b00) ? 2 : 11;
  endfunction

  // Starts a sequence and plays the bus controller; dmin=0 means never answer.
  task automatic run_seq(input logic [1:0] m, input int dmin, input int dmax,
                         input bit poke, input int budget);
    int wait_cnt;
    wait_cnt = 0;
    obs_q.delete();
    n_lista = 0; lista_code = '0; code_done = '1;
    c_ult_inicio = -1; c_lista = -1; c_done = -1; done = 0;
    modo = m; iniciar = 1'b1;
    tick;
    iniciar = 1'b0;
    modo = 2'($urandom);
    err_at_start = error_timeout;
    for (int c = 0; c < budget && !done; c++) begin
      fin_transaccion = 1'b0;
      iniciar = 1'b0;
      if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) fin_transaccion = 1'b1;
      end
      if (inicio_transaccion) begin
        obs_q.push_back(Selec_Mux_DD);
        c_ult_inicio = c;
        if (dmin > 0) wait_cnt = $urandom_range(dmax, dmin);
        if (poke) begin
          fin_transaccion = 1'b1;
          iniciar = 1'b1;
          modo = 2'b00;
        end
      end
      if (secuencia_lista) begin
        n_lista++;
        lista_code = Selec_Mux_DD;
        c_lista = c;
      end
      if (!ocupado) begin
        done = 1;
        c_done = c;
        code_done = Selec_Mux_DD;
      end
      if (!done) tick;
    end
    fin_transaccion = 1'b0;
    iniciar = 1'b0;
  endtask

  task automatic check_success(input string tag, input logic [1:0] m);
    int nexp;
    nexp = exp_last(m) - exp_first(m) + 1;
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL %s_done: sequence did not return to idle", tag); end
    n_checks++;
    if (obs_q.size() !== nexp) begin n_fail++; $display("FAIL %s_nreq: got %0d requests, want %0d", tag, obs_q.size(), nexp); end
    for (int i = 0; i < nexp && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== 4'(exp_first(m) + i)) begin
        n_fail++; $display("FAIL %s_code[%0d]: got %h want %h", tag, i, obs_q[i], 4'(exp_first(m) + i));
      end
    end
    n_checks++;
    if (n_lista !== 1 || lista_code !== 4'(exp_last(m))) begin
      n_fail++; $display("FAIL %s_lista: got %0d pulses code %h, want 1 pulse code %h", tag, n_lista, lista_code, 4'(exp_last(m)));
    end
    n_checks++;
    if (c_done !== c_lista + 1 || code_done !== 4'h0) begin
      n_fail++; $display("FAIL %s_end: idle at cycle %0d code %h, want cycle %0d code 0", tag, c_done, code_done, c_lista + 1);
    end
    n_checks++;
    if (err_at_start !== 1'b0 || error_timeout !== 1'b0) begin
      n_fail++; $display("FAIL %s_err: got %b/%b want 0/0", tag, err_at_start, error_timeout);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    n_checks++;
    if ({Selec_Mux_DD, inicio_transaccion, ocupado, secuencia_lista, error_timeout} !== 8'h00) begin
      n_fail++; $display("FAIL reset_outputs: got code=%h req=%b busy=%b lista=%b err=%b want all 0",
                         Selec_Mux_DD, inicio_transaccion, ocupado, secuencia_lista, error_timeout);
    end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_init;
    run_seq(2'b00, 3, 3, 1'b0, 100);
    check_success("init", 2'b00);
  endtask

  task automatic test_read;
    for (int k = 0; k < 3; k++) begin
      run_seq(2'b01, 1, 6, 1'b0, 300);
      check_success("read", 2'b01);
      tick;
    end
  endtask

  task automatic test_ignored;
    fin_transaccion = 1'b1;
    tick; tick; tick;
    fin_transaccion = 1'b0;
    n_checks++;
    if (Selec_Mux_DD !== 4'h0 || ocupado !== 1'b0 || inicio_transaccion !== 1'b0) begin
      n_fail++; $display("FAIL fin_idle: got code=%h busy=%b req=%b want 0/0/0", Selec_Mux_DD, ocupado, inicio_transaccion);
    end
    modo = 2'b11; iniciar = 1'b1;
    tick;
    iniciar = 1'b0;
    n_checks++;
    if (ocupado !== 1'b0 || Selec_Mux_DD !== 4'h0 || inicio_transaccion !== 1'b0) begin
      n_fail++; $display("FAIL modo11: got busy=%b code=%h req=%b want 0/0/0", ocupado, Selec_Mux_DD, inicio_transaccion);
    end
    tick;
    // fin during PEDIR plus iniciar while busy must not disturb the crono walk
    run_seq(2'b10, 1, 5, 1'b1, 200);
    check_success("crono_poke", 2'b10);
    tick;
  endtask

  task automatic test_timeout;
    run_seq(2'b10, 0, 0, 1'b0, 400);
    n_checks++;
    if (done !== 1'b1 || c_done - c_ult_inicio !== 256) begin
      n_fail++; $display("FAIL timeout_time: idle %0d cycles after request (done=%b), want 256", c_done - c_ult_inicio, done);
    end
    n_checks++;
    if (obs_q.size() !== 1 || (obs_q.size() > 0 && obs_q[0] !== 4'h9)) begin
      n_fail++; $display("FAIL timeout_req: got %0d requests, want 1 at code 9", obs_q.size());
    end
    n_checks++;
    if (error_timeout !== 1'b1 || code_done !== 4'h0 || n_lista !== 0) begin
      n_fail++; $display("FAIL timeout_state: got err=%b code=%h lista=%0d want 1/0/0", error_timeout, code_done, n_lista);
    end
    for (int i = 0; i < 5; i++) tick;
    modo = 2'b11; iniciar = 1'b1;
    tick;
    iniciar = 1'b0;
    n_checks++;
    if (error_timeout !== 1'b1) begin
      n_fail++; $display("FAIL timeout_sticky: got err=%b want 1", error_timeout);
    end
    tick;
    run_seq(2'b00, 1, 3, 1'b0, 100);
    check_success("after_timeout", 2'b00);
    tick;
  endtask

  task automatic test_fin_vs_timeout;
    run_seq(2'b00, 255, 255, 1'b0, 700);
    check_success("fin_on_timeout_edge", 2'b00);
    tick;
    run_seq(2'b00, 256, 256, 1'b0, 400);
    n_checks++;
    if (done !== 1'b1 || obs_q.size() !== 1 || error_timeout !== 1'b1 || n_lista !== 0) begin
      n_fail++; $display("FAIL fin_too_late: got done=%b nreq=%0d err=%b lista=%0d want 1/1/1/0",
                         done, obs_q.size(), error_timeout, n_lista);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    int  wait_cnt;
    bit  hit;
    int  bad;
    wait_cnt = 0; hit = 0; bad = 0;
    modo = 2'b01; iniciar = 1'b1;
    tick;
    iniciar = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      fin_transaccion = 1'b0;
      if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) fin_transaccion = 1'b1;
      end
      if (inicio_transaccion) wait_cnt = 2;
      if (ocupado && !inicio_transaccion && Selec_Mux_DD == 4'h6) begin
        hit = 1;
        fin_transaccion = 1'b0;
        reset = 1'b1;
      end
      tick;
    end
    reset = 1'b0;
    fin_transaccion = 1'b0;
    n_checks++;
    if (hit !== 1'b1 || {Selec_Mux_DD, inicio_transaccion, ocupado, secuencia_lista, error_timeout} !== 8'h00) begin
      n_fail++; $display("FAIL reset_mid: hit=%b code=%h req=%b busy=%b lista=%b err=%b want all 0",
                         hit, Selec_Mux_DD, inicio_transaccion, ocupado, secuencia_lista, error_timeout);
    end
    for (int i = 0; i < 6; i++) begin
      if (secuencia_lista || ocupado || inicio_transaccion) bad++;
      tick;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL reset_mid_quiet: got %0d active cycles after reset, want 0", bad);
    end
  endtask

  initial begin
    test_reset;
    test_init;
    test_read;
    test_ignored;
    test_timeout;
    test_fin_vs_timeout;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
